queue_calc_ctrl: RTL and testbench
==================================

QUEUE_CALC_CTRL -- requirements
Module: queue_calc_ctrl

Interface
REQ-001 Parameters: QDEPTH, default 5, queue capacity in bytes; IDLE_POS, default 3'd7, out-of-range write index used as the no-op slot.
REQ-002 Port clk  in  1  the single clock; all flops on its rising edge.
REQ-003 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 Port tok_valid  in  1  upstream token valid.
REQ-005 Port tok_ready  out  1  token accepted when tok_valid and tok_ready are high at a rising edge.
REQ-006 Port tok_kind  in  2  token kind: 00 operand, 01 operator, 10 pop, 11 clear.
REQ-007 Port tok_data  in  8  operand byte; for operators, [1:0] selects 00 add, 01 sub, 10 and, 11 xor.
REQ-008 Port q_back  out  8  byte written into the queue.
REQ-009 Port q_pos_back  out  3  queue write index.
REQ-010 Port q_opcode  out  2  queue opcode: 00 push, 10 pop pair, 11 pop front.
REQ-011 Port q_rst  out  1  synchronous active-high reset to the queue.
REQ-012 Port q_top_conc  in  16  queue output {older byte, newer byte}, valid the cycle after a pop.
REQ-013 Port count  out  3  logical queue occupancy, 0..QDEPTH.
REQ-014 Port result / result_valid  out  8 / 1  last computed or popped byte; one-cycle strobe when result updates.
REQ-015 Port err_ovf / err_unf  out  1 / 1  sticky overflow and underflow flags.

Function
REQ-016 All q_* outputs, count, result and flags SHALL be registered.
REQ-017 Idle command SHALL be q_opcode 00, q_pos_back IDLE_POS, q_back 0, q_rst 0; it SHALL be driven in every cycle with no other command.
REQ-018 FSM states SHALL be IDLE, P2_WAIT, P2_CAP, PUSH_RES, P1_WAIT, P1_CAP.
REQ-019 tok_ready SHALL be high only in IDLE.
REQ-020 Operand, count<QDEPTH: register push (00, pos=count, back=tok_data) for one cycle, count+1, stay IDLE.
REQ-021 Operand, count==QDEPTH: set err_ovf, drop the token, count unchanged, issue no write.
REQ-022 Operator, count>=2: register opcode 10 with pos IDLE_POS, count-2, go to P2_WAIT.
REQ-023 P2_WAIT: drive idle, go to P2_CAP; P2_CAP: r = q_top_conc[15:8] op q_top_conc[7:0], register push (pos=count, back=r), count+1, result=r, result_valid=1, go to PUSH_RES.
REQ-024 PUSH_RES: drive idle, go to IDLE; an operator token keeps tok_ready low for exactly 3 cycles.
REQ-025 Arithmetic SHALL be 8-bit modulo 256; sub is older minus newer, wrap-around, no carry or borrow output.
REQ-026 Operator with count<2, or pop with count==0: set err_unf, drop the token, issue no queue command.
REQ-027 Pop, count>=1: register opcode 11 with pos IDLE_POS, count-1, go to P1_WAIT; P1_WAIT drives idle, then P1_CAP; P1_CAP sets result=q_top_conc[15:8], result_valid=1, then IDLE.
REQ-028 Clear: q_rst=1 for one cycle, count=0, err_ovf and err_unf cleared, stay IDLE.
REQ-029 result_valid SHALL be high for exactly one cycle per result.

Reset
REQ-030 While rst_n is low, asynchronously: state IDLE, count 0, idle command, q_rst 0, result 0, result_valid 0, both error flags 0.
REQ-031 Reset mid-operation SHALL abandon the sequence and issue no partial push after release.
REQ-032 Queue contents are not cleared by rst_n; a clear token is required after reset.

Structure
REQ-033 Package queue_calc_pkg SHALL hold the opcode constants, token-kind constants, ALU op codes, the FSM state enum, QDEPTH and IDLE_POS.
REQ-034 Combinational sub-module queue_calc_alu (a, b, op -> r) SHALL implement REQ-025.

Verification
REQ-035 Clear, operands 0x05, 0x03, operator add -> pushes at pos 0 and 1; pop pair; push 0x08 at pos 0; result 0x08; count 1.
REQ-036 Operands 0x02, 0x05, operator sub -> result 0xFD (wrap); err flags 0.
REQ-037 Six operands -> fifth push at pos 4; sixth dropped; err_ovf=1; count 5; clear -> err_ovf=0, count 0.
REQ-038 One operand, operator -> err_unf=1; no opcode 10 issued; count 1.
REQ-039 Operands 0xA5, 0x0F, pop -> result 0xA5; count 1; following operand pushes at pos 1.
REQ-040 rst_n low in P2_CAP -> idle command immediately, count 0; after release no push occurs and tok_ready=1.

Source files
------------

// File: rtl/queue_calc_pkg.sv
// Shared definitions for the queue calculator controller.
//   - Queue command opcodes and the idle write slot
//   - Token kinds and ALU operation codes
//   - FSM state enumeration
//   - Default queue depth
package queue_calc_pkg;

    localparam int         QDEPTH   = 5;
    localparam logic [2:0] IDLE_POS = 3'd7;

    // Queue command opcodes
    localparam logic [1:0] QOP_PUSH = 2'b00;
    localparam logic [1:0] QOP_POP2 = 2'b10;
    localparam logic [1:0] QOP_POP1 = 2'b11;

    // Token kinds
    localparam logic [1:0] KIND_OPND = 2'b00;
    localparam logic [1:0] KIND_OPER = 2'b01;
    localparam logic [1:0] KIND_POP  = 2'b10;
    localparam logic [1:0] KIND_CLR  = 2'b11;

    // ALU operations (taken from tok_data[1:0] of an operator token)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P2_WAIT  = 3'd1,
        P2_CAP   = 3'd2,
        PUSH_RES = 3'd3,
        P1_WAIT  = 3'd4,
        P1_CAP   = 3'd5
    } state_t;

endpackage

// File: rtl/queue_calc_alu.sv
// Combinational 8-bit ALU for the queue calculator.
// Ports:
//   a  - older operand byte
//   b  - newer operand byte
//   op - operation select (add, sub, and, xor)
//   r  - result, modulo 256; sub is a - b with wrap-around
module queue_calc_alu
    import queue_calc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] r
);

    always_comb begin
        r = 8'h00;
        unique case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            default: r = 8'h00;
        endcase
    end

endmodule

// File: rtl/queue_calc_ctrl.sv
// Token-driven controller for an external byte queue used as a calculator.
// Operands are pushed; operators pop the two oldest bytes, combine them and
// push the result; pop returns the oldest byte; clear resets the queue.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   tok_valid/tok_ready - token handshake (ready only in IDLE)
//   tok_kind, tok_data  - token kind and operand byte / ALU op select
//   q_back, q_pos_back, q_opcode, q_rst - registered queue command
//   q_top_conc          - queue output {older, newer}, valid the cycle after a pop
//   count               - logical queue occupancy
//   result/result_valid - last computed or popped byte, one-cycle strobe
//   err_ovf / err_unf   - sticky overflow / underflow flags (cleared by clear token)
module queue_calc_ctrl #(
    parameter int         QDEPTH   = queue_calc_pkg::QDEPTH,
    parameter logic [2:0] IDLE_POS = queue_calc_pkg::IDLE_POS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic [1:0]  tok_kind,
    input  logic [7:0]  tok_data,
    output logic [7:0]  q_back,
    output logic [2:0]  q_pos_back,
    output logic [1:0]  q_opcode,
    output logic        q_rst,
    input  logic [15:0] q_top_conc,
    output logic [2:0]  count,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        err_ovf,
    output logic        err_unf
);

    import queue_calc_pkg::*;

    localparam logic [2:0] DEPTH_C = 3'(QDEPTH);

    state_t     state, state_nxt;
    logic       accept;
    logic [1:0] op_q;
    logic [7:0] alu_r;

    logic [7:0] q_back_d;
    logic [2:0] q_pos_d;
    logic [1:0] q_op_d;
    logic       q_rst_d;
    logic [2:0] count_d;
    logic [7:0] result_d;
    logic       rv_d;
    logic       ovf_d;
    logic       unf_d;

    assign tok_ready = (state == IDLE);
    assign accept    = tok_valid && tok_ready;

    queue_calc_alu u_alu (
        .a  (q_top_conc[15:8]),
        .b  (q_top_conc[7:0]),
        .op (op_q),
        .r  (alu_r)
    );

    // ALU op of the accepted operator is held until the capture state
    always_ff @(posedge clk) begin
        if (accept && tok_kind == KIND_OPER) begin
            op_q <= tok_data[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (tok_valid) begin
                    if (tok_kind == KIND_OPER && count >= 3'd2) begin
                        state_nxt = P2_WAIT;
                    end else if (tok_kind == KIND_POP && count != 3'd0) begin
                        state_nxt = P1_WAIT;
                    end
                end
            end
            P2_WAIT:  state_nxt = P2_CAP;
            P2_CAP:   state_nxt = PUSH_RES;
            PUSH_RES: state_nxt = IDLE;
            P1_WAIT:  state_nxt = P1_CAP;
            P1_CAP:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values of all registered outputs; the idle command is the default
    // so any cycle without an explicit command drives it.
    always_comb begin
        q_back_d = 8'h00;
        q_pos_d  = IDLE_POS;
        q_op_d   = QOP_PUSH;
        q_rst_d  = 1'b0;
        count_d  = count;
        result_d = result;
        rv_d     = 1'b0;
        ovf_d    = err_ovf;
        unf_d    = err_unf;
        unique case (state)
            IDLE: begin
                if (tok_valid) begin
                    unique case (tok_kind)
                        KIND_OPND: begin
                            if (count < DEPTH_C) begin
                                q_pos_d  = count;
                                q_back_d = tok_data;
                                count_d  = count + 3'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        KIND_OPER: begin
                            if (count >= 3'd2) begin
                                q_op_d  = QOP_POP2;
                                count_d = count - 3'd2;
                            end else begin
                                unf_d = 1'b1;
                            end
                        end
                        KIND_POP: begin
                            if (count != 3'd0) begin
                                q_op_d  = QOP_POP1;
                                count_d = count - 3'd1;
                            end else begin
                                unf_d = 1'b1;
                            end
                        end
                        default: begin
                            q_rst_d = 1'b1;
                            count_d = 3'd0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
                    endcase
                end
            end
            P2_CAP: begin
                // Pair popped two cycles ago is now on q_top_conc
                q_pos_d  = count;
                q_back_d = alu_r;
                count_d  = count + 3'd1;
                result_d = alu_r;
                rv_d     = 1'b1;
            end
            P1_CAP: begin
                result_d = q_top_conc[15:8];
                rv_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_back       <= 8'h00;
            q_pos_back   <= IDLE_POS;
            q_opcode     <= QOP_PUSH;
            q_rst        <= 1'b0;
            count        <= 3'd0;
            result       <= 8'h00;
            result_valid <= 1'b0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
        end else begin
            q_back       <= q_back_d;
            q_pos_back   <= q_pos_d;
            q_opcode     <= q_op_d;
            q_rst        <= q_rst_d;
            count        <= count_d;
            result       <= result_d;
            result_valid <= rv_d;
            err_ovf      <= ovf_d;
            err_unf      <= unf_d;
        end
    end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Self-checking bench for queue_calc_ctrl: an external shifting byte queue
// model, a token-level reference model, a directed vector table, random
// tokens and a reset-in-flight sequence.
module tb_queue_calc_ctrl;

    import queue_calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_kind;
    logic [7:0]  tok_data;
    logic [7:0]  q_back;
    logic [2:0]  q_pos_back;
    logic [1:0]  q_opcode;
    logic        q_rst;
    logic [15:0] q_top_conc;
    logic [2:0]  count;
    logic [7:0]  result;
    logic        result_valid;
    logic        err_ovf;
    logic        err_unf;

    int total = 0;
    int bad   = 0;

    queue_calc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_kind     (tok_kind),
        .tok_data     (tok_data),
        .q_back       (q_back),
        .q_pos_back   (q_pos_back),
        .q_opcode     (q_opcode),
        .q_rst        (q_rst),
        .q_top_conc   (q_top_conc),
        .count        (count),
        .result       (result),
        .result_valid (result_valid),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
    );

    always #5 clk = ~clk;

    // External queue: positional writes, pops take from the front and shift.
    logic [7:0] qmem [0:7];
    int push_cnt = 0, pop2_cnt = 0, pop1_cnt = 0, rst_cnt = 0, rv_cnt = 0;
    int last_pos = 0;
    logic [7:0] last_back = 8'h00;

    always @(posedge clk) begin
        if (result_valid) rv_cnt <= rv_cnt + 1;
        if (q_rst) begin
            rst_cnt <= rst_cnt + 1;
            for (int i = 0; i < 8; i++) qmem[i] <= 8'h00;
        end else if (q_opcode == QOP_POP2) begin
            pop2_cnt   <= pop2_cnt + 1;
            q_top_conc <= {qmem[0], qmem[1]};
            for (int i = 0; i < 6; i++) qmem[i] <= qmem[i+2];
        end else if (q_opcode == QOP_POP1) begin
            pop1_cnt   <= pop1_cnt + 1;
            q_top_conc <= {qmem[0], qmem[1]};
            for (int i = 0; i < 7; i++) qmem[i] <= qmem[i+1];
        end else if (q_opcode == QOP_PUSH && q_pos_back != IDLE_POS) begin
            push_cnt  <= push_cnt + 1;
            last_pos  <= int'(q_pos_back);
            last_back <= q_back;
            qmem[q_pos_back] <= q_back;
        end
    end

    // Reference model: logical queue contents and visible state
    logic [7:0] mq[$];
    logic [7:0] m_res = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
        int x;
        case (op)
            2'd0:    x = (int'(a) + int'(b)) % 256;
            2'd1:    x = (int'(a) - int'(b) + 256) % 256;
            2'd2:    x = int'(a & b);
            default: x = int'(a ^ b);
        endcase
        return x[7:0];
    endfunction

    function automatic void model_apply(input logic [1:0] k, input logic [7:0] d,
                                        output bit e_push, output bit e_pop2,
                                        output bit e_pop1, output bit e_rst,
                                        output bit e_rv, output int e_pos,
                                        output logic [7:0] e_back);
        logic [7:0] a, b, r;
        e_push = 0; e_pop2 = 0; e_pop1 = 0; e_rst = 0; e_rv = 0;
        e_pos = 0; e_back = 8'h00;
        case (k)
            2'd0: begin
                if (mq.size() < QDEPTH) begin
                    mq.push_back(d);
                    e_push = 1; e_pos = mq.size() - 1; e_back = d;
                end else m_ovf = 1'b1;
            end
            2'd1: begin
                if (mq.size() >= 2) begin
                    a = mq.pop_front();
                    b = mq.pop_front();
                    r = calc(a, b, d[1:0]);
                    mq.push_back(r);
                    m_res = r;
                    e_pop2 = 1; e_push = 1; e_rv = 1;
                    e_pos = mq.size() - 1; e_back = r;
                end else m_unf = 1'b1;
            end
            2'd2: begin
                if (mq.size() >= 1) begin
                    m_res = mq.pop_front();
                    e_pop1 = 1; e_rv = 1;
                end else m_unf = 1'b1;
            end
            default: begin
                mq.delete();
                m_ovf = 1'b0; m_unf = 1'b0;
                e_rst = 1;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] d);
        bit e_push, e_pop2, e_pop1, e_rst, e_rv;
        int e_pos, g, low;
        int p0, o2, o1, r0, v0;
        logic [7:0] e_back;
        model_apply(k, d, e_push, e_pop2, e_pop1, e_rst, e_rv, e_pos, e_back);
        g = 0;
        while (!tok_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (!tok_ready) check("ready_timeout", 32'(tok_ready), 32'd1);
        p0 = push_cnt; o2 = pop2_cnt; o1 = pop1_cnt; r0 = rst_cnt; v0 = rv_cnt;
        tok_valid = 1'b1; tok_kind = k; tok_data = d;
        @(posedge clk); #1;
        tok_valid = 1'b0;
        low = 0;
        while (!tok_ready && low < 50) begin @(posedge clk); #1; low++; end
        @(posedge clk); #1;
        check("count",   32'(count),   32'(mq.size()));
        check("result",  32'(result),  32'(m_res));
        check("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check("err_unf", 32'(err_unf), 32'(m_unf));
        check("pushes",  32'(push_cnt - p0), 32'(e_push));
        check("pop2s",   32'(pop2_cnt - o2), 32'(e_pop2));
        check("pop1s",   32'(pop1_cnt - o1), 32'(e_pop1));
        check("q_rsts",  32'(rst_cnt - r0),  32'(e_rst));
        check("result_valid_pulses", 32'(rv_cnt - v0), 32'(e_rv));
        if (e_push) begin
            check("push_pos",  32'(last_pos),  32'(e_pos));
            check("push_back", 32'(last_back), 32'(e_back));
        end
        if (e_pop2) check("oper_ready_low_cycles", 32'(low), 32'd3);
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        logic [7:0] res;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl [28];

    initial begin
        int p0, v0, sel;
        tbl[0]  = '{2'd3, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 8'h05, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 8'h03, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[3]  = '{2'd1, 8'h00, 8'h08, 3'd1, 1'b0, 1'b0};
        tbl[4]  = '{2'd3, 8'h00, 8'h08, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{2'd0, 8'h02, 8'h08, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{2'd0, 8'h05, 8'h08, 3'd2, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 8'h01, 8'hFD, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{2'd3, 8'h00, 8'hFD, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{2'd0, 8'h11, 8'hFD, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{2'd0, 8'h22, 8'hFD, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{2'd0, 8'h33, 8'hFD, 3'd3, 1'b0, 1'b0};
        tbl[12] = '{2'd0, 8'h44, 8'hFD, 3'd4, 1'b0, 1'b0};
        tbl[13] = '{2'd0, 8'h55, 8'hFD, 3'd5, 1'b0, 1'b0};
        tbl[14] = '{2'd0, 8'h66, 8'hFD, 3'd5, 1'b1, 1'b0};
        tbl[15] = '{2'd3, 8'h00, 8'hFD, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{2'd0, 8'h09, 8'hFD, 3'd1, 1'b0, 1'b0};
        tbl[17] = '{2'd1, 8'h00, 8'hFD, 3'd1, 1'b0, 1'b1};
        tbl[18] = '{2'd3, 8'h00, 8'hFD, 3'd0, 1'b0, 1'b0};
        tbl[19] = '{2'd0, 8'hA5, 8'hFD, 3'd1, 1'b0, 1'b0};
        tbl[20] = '{2'd0, 8'h0F, 8'hFD, 3'd2, 1'b0, 1'b0};
        tbl[21] = '{2'd2, 8'h00, 8'hA5, 3'd1, 1'b0, 1'b0};
        tbl[22] = '{2'd0, 8'h77, 8'hA5, 3'd2, 1'b0, 1'b0};
        tbl[23] = '{2'd1, 8'h02, 8'h07, 3'd1, 1'b0, 1'b0};
        tbl[24] = '{2'd0, 8'hF0, 8'h07, 3'd2, 1'b0, 1'b0};
        tbl[25] = '{2'd1, 8'h03, 8'hF7, 3'd1, 1'b0, 1'b0};
        tbl[26] = '{2'd2, 8'h00, 8'hF7, 3'd0, 1'b0, 1'b0};
        tbl[27] = '{2'd2, 8'h00, 8'hF7, 3'd0, 1'b0, 1'b1};

        rst_n = 1'b0; tok_valid = 1'b0; tok_kind = 2'd0; tok_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tok_ready",    32'(tok_ready),    32'd1);
        check("rst_q_opcode",     32'(q_opcode),     32'd0);
        check("rst_q_pos_back",   32'(q_pos_back),   32'd7);
        check("rst_q_back",       32'(q_back),       32'd0);
        check("rst_q_rst",        32'(q_rst),        32'd0);
        check("rst_count",        32'(count),        32'd0);
        check("rst_result",       32'(result),       32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_err_ovf",      32'(err_ovf),      32'd0);
        check("rst_err_unf",      32'(err_unf),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 28; i++) begin
            send(tbl[i].kind, tbl[i].data);
            check($sformatf("tbl%0d_result", i), 32'(result),  32'(tbl[i].res));
            check($sformatf("tbl%0d_count", i),  32'(count),   32'(tbl[i].cnt));
            check($sformatf("tbl%0d_ovf", i),    32'(err_ovf), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_unf", i),    32'(err_unf), 32'(tbl[i].unf));
        end

        // Random tokens against the reference model
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45)      send(2'd0, 8'($urandom));
            else if (sel < 70) send(2'd1, 8'($urandom));
            else if (sel < 90) send(2'd2, 8'($urandom));
            else               send(2'd3, 8'($urandom));
        end

        // Reset while the operator sequence sits in P2_CAP
        send(2'd3, 8'h00);
        send(2'd0, 8'h01);
        send(2'd0, 8'h02);
        tok_valid = 1'b1; tok_kind = 2'd1; tok_data = 8'h00;
        @(posedge clk); #1;
        tok_valid = 1'b0;
        @(posedge clk); #1;
        check("p2cap_tok_ready", 32'(tok_ready), 32'd0);
        p0 = push_cnt; v0 = rv_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_q_opcode",   32'(q_opcode),   32'd0);
        check("midrst_q_pos_back", 32'(q_pos_back), 32'd7);
        check("midrst_q_back",     32'(q_back),     32'd0);
        check("midrst_count",      32'(count),      32'd0);
        check("midrst_tok_ready",  32'(tok_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_pushes",    32'(push_cnt - p0), 32'd0);
        check("postrst_rv",        32'(rv_cnt - v0),   32'd0);
        check("postrst_tok_ready", 32'(tok_ready),     32'd1);
        check("postrst_count",     32'(count),         32'd0);
        check("postrst_result",    32'(result),        32'd0);
        mq.delete(); m_res = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        send(2'd3, 8'h00);
        send(2'd0, 8'h40);
        send(2'd0, 8'h50);
        send(2'd1, 8'h00);
        check("after_rst_sum", 32'(result), 32'h90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
